// File: rtl/axi_lite_master_pkg.sv
// axi_lite_master_pkg.sv - shared AXI4-Lite response codes and master FSM state encoding.
package axi_lite_master_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_W_REQ = 3'd1,
        ST_W_RSP = 3'd2,
        ST_R_REQ = 3'd3,
        ST_R_RSP = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // States in which a transaction is waiting on the slave.
    function automatic logic state_waiting(input state_t s);
        return (s != ST_IDLE) && (s != ST_DONE);
    endfunction

endpackage

// File: rtl/axi_lite_master.sv
// axi_lite_master.sv - single-outstanding AXI4-Lite initiator for local register commands.
// Optional response timeout is compiled in with `define AXI_MASTER_TIMEOUT_EN.
module axi_lite_master
    import axi_lite_master_pkg::*;
#(
    parameter int ADDR_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_write,
    input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [31:0]           i_cmd_wdata,
    input  logic [3:0]            i_cmd_wstrb,
    output logic                  o_rsp_valid,
    output logic [1:0]            o_rsp_resp,
    output logic [31:0]           o_rsp_data,
    output logic                  o_rsp_timeout,
    output logic                  o_awvalid,
    output logic [ADDR_WIDTH-1:0] o_awaddr,
    input  logic                  i_awready,
    output logic                  o_wvalid,
    output logic [31:0]           o_wdata,
    output logic [3:0]            o_wstrb,
    input  logic                  i_wready,
    input  logic                  i_bvalid,
    output logic                  o_bready,
    input  logic [1:0]            i_bresp,
    output logic                  o_arvalid,
    output logic [ADDR_WIDTH-1:0] o_araddr,
    input  logic                  i_arready,
    input  logic                  i_rvalid,
    output logic                  o_rready,
    input  logic [1:0]            i_rresp,
    input  logic [31:0]           i_rdata
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ALIGN_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

    state_t                r_state;
    state_t                w_state_norm;
    state_t                w_state_nxt;
    logic                  r_cmd_ready;
    logic                  r_awvalid;
    logic                  r_wvalid;
    logic                  r_bready;
    logic                  r_arvalid;
    logic                  r_rready;
    logic                  r_rsp_valid;
    logic [1:0]            r_rsp_resp;
    logic [31:0]           r_rsp_data;
    logic [ADDR_WIDTH-1:0] r_awaddr;
    logic [ADDR_WIDTH-1:0] r_araddr;
    logic [31:0]           r_wdata;
    logic [3:0]            r_wstrb;

    logic                  w_accept;
    logic                  w_aw_pending;
    logic                  w_w_pending;
    logic                  w_capture;
    logic [1:0]            w_cap_resp;
    logic [31:0]           w_cap_data;
    logic                  w_timeout_fire;
    logic                  w_awvalid_nxt;
    logic                  w_wvalid_nxt;
    logic [ADDR_WIDTH-1:0] w_cmd_addr_aligned;

    assign w_accept           = i_cmd_valid && r_cmd_ready;
    assign w_aw_pending       = r_awvalid && !i_awready;
    assign w_w_pending        = r_wvalid && !i_wready;
    assign w_cmd_addr_aligned = i_cmd_addr & ADDR_ALIGN_MASK;

    // Handshake-driven next state and response capture, before any timeout override.
    always_comb begin
        w_state_norm = r_state;
        w_capture    = 1'b0;
        w_cap_resp   = AXI_RESP_OKAY;
        w_cap_data   = 32'h0000_0000;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (i_cmd_write) begin
                        w_state_norm = ST_W_REQ;
                    end else begin
                        w_state_norm = ST_R_REQ;
                    end
                end else begin
                    w_state_norm = ST_IDLE;
                end
            end
            ST_W_REQ: begin
                if (!w_aw_pending && !w_w_pending) begin
                    w_state_norm = ST_W_RSP;
                end else begin
                    w_state_norm = ST_W_REQ;
                end
            end
            ST_W_RSP: begin
                if (i_bvalid) begin
                    w_state_norm = ST_DONE;
                    w_capture    = 1'b1;
                    w_cap_resp   = i_bresp;
                end else begin
                    w_state_norm = ST_W_RSP;
                end
            end
            ST_R_REQ: begin
                if (i_arready) begin
                    w_state_norm = ST_R_RSP;
                end else begin
                    w_state_norm = ST_R_REQ;
                end
            end
            ST_R_RSP: begin
                if (i_rvalid) begin
                    w_state_norm = ST_DONE;
                    w_capture    = 1'b1;
                    w_cap_resp   = i_rresp;
                    w_cap_data   = i_rdata;
                end else begin
                    w_state_norm = ST_R_RSP;
                end
            end
            ST_DONE: begin
                w_state_norm = ST_IDLE;
            end
            default: begin
                w_state_norm = ST_IDLE;
            end
        endcase
    end

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam int               TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};

    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_rsp_timeout;

    // Expiry is the edge on which the count reaches TIMEOUT_CYCLES; any handshake on that edge takes precedence.
    assign w_timeout_fire = state_waiting(r_state) && (r_tmo_cnt == TMO_LAST) &&
                            (w_state_norm == r_state);

    // Cycles spent waiting on the slave since the command was accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= {TMO_W{1'b0}};
        end else if (w_accept) begin
            r_tmo_cnt <= {TMO_W{1'b0}};
        end else if (state_waiting(r_state)) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_ONE;
        end else begin
            r_tmo_cnt <= r_tmo_cnt;
        end
    end

    // Timeout flag, refreshed together with the other response fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_timeout <= 1'b0;
        end else if (w_state_nxt == ST_DONE) begin
            r_rsp_timeout <= w_timeout_fire;
        end else begin
            r_rsp_timeout <= r_rsp_timeout;
        end
    end

    assign o_rsp_timeout = r_rsp_timeout;
`else
    assign w_timeout_fire = 1'b0;
    assign o_rsp_timeout  = 1'b0;
`endif

    // Final next state and per-channel write valids.
    always_comb begin
        if (w_timeout_fire) begin
            w_state_nxt = ST_DONE;
        end else begin
            w_state_nxt = w_state_norm;
        end
        w_awvalid_nxt = 1'b0;
        w_wvalid_nxt  = 1'b0;
        if (w_state_nxt == ST_W_REQ) begin
            if (r_state == ST_IDLE) begin
                w_awvalid_nxt = 1'b1;
                w_wvalid_nxt  = 1'b1;
            end else begin
                w_awvalid_nxt = w_aw_pending;
                w_wvalid_nxt  = w_w_pending;
            end
        end else begin
            w_awvalid_nxt = 1'b0;
            w_wvalid_nxt  = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered handshake outputs, decoded from the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd_ready <= 1'b0;
            r_awvalid   <= 1'b0;
            r_wvalid    <= 1'b0;
            r_bready    <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            r_cmd_ready <= (w_state_nxt == ST_IDLE);
            r_awvalid   <= w_awvalid_nxt;
            r_wvalid    <= w_wvalid_nxt;
            r_bready    <= (w_state_nxt == ST_W_RSP);
            r_arvalid   <= (w_state_nxt == ST_R_REQ);
            r_rready    <= (w_state_nxt == ST_R_RSP);
            r_rsp_valid <= (w_state_nxt == ST_DONE);
        end
    end

    // Command latch; fields stay stable for the whole transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_awaddr <= {ADDR_WIDTH{1'b0}};
            r_araddr <= {ADDR_WIDTH{1'b0}};
            r_wdata  <= 32'h0000_0000;
            r_wstrb  <= 4'h0;
        end else if (w_accept && i_cmd_write) begin
            r_awaddr <= w_cmd_addr_aligned;
            r_wdata  <= i_cmd_wdata;
            r_wstrb  <= i_cmd_wstrb;
        end else if (w_accept) begin
            r_araddr <= w_cmd_addr_aligned;
        end else begin
            r_awaddr <= r_awaddr;
            r_araddr <= r_araddr;
            r_wdata  <= r_wdata;
            r_wstrb  <= r_wstrb;
        end
    end

    // Response fields hold until the next completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_resp <= AXI_RESP_OKAY;
            r_rsp_data <= 32'h0000_0000;
        end else if (w_timeout_fire) begin
            r_rsp_resp <= AXI_RESP_SLVERR;
            r_rsp_data <= 32'h0000_0000;
        end else if (w_capture) begin
            r_rsp_resp <= w_cap_resp;
            r_rsp_data <= w_cap_data;
        end else begin
            r_rsp_resp <= r_rsp_resp;
            r_rsp_data <= r_rsp_data;
        end
    end

    assign o_cmd_ready = r_cmd_ready;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_resp  = r_rsp_resp;
    assign o_rsp_data  = r_rsp_data;
    assign o_awvalid   = r_awvalid;
    assign o_awaddr    = r_awaddr;
    assign o_wvalid    = r_wvalid;
    assign o_wdata     = r_wdata;
    assign o_wstrb     = r_wstrb;
    assign o_bready    = r_bready;
    assign o_arvalid   = r_arvalid;
    assign o_araddr    = r_araddr;
    assign o_rready    = r_rready;

endmodule
